// File: rtl/whack_a_mole_game_controller.sv
// Whack-a-mole game controller: owns the game FSM, millisecond timebase,
// pre-game countdown, game timer, mole up/down pacing, difficulty level and
// the persistent high score.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   start_pressed, pause_pressed one-cycle debounced button pulses
//   hit, miss                    one-cycle pulses from the hit logic
//   score                        current score from the score keeper
//   state                        0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 PAUSED, 4 GAME_OVER
//   game_in_progress             high only in PLAY
//   countdown_value              pre-game seconds remaining
//   seconds_left, ms_left        game time remaining (seconds rounded up, ms)
//   mole_up, mole_tick           mole phase level, pulse on each new up phase
//   level                        current difficulty level
//   game_over_pulse              pulse on PLAY->GAME_OVER
//   high_score, new_high_score   best score since reset, last game beat it
module whack_a_mole_game_controller #(
  parameter int unsigned CLKS_PER_MS         = 50000,
  parameter int unsigned GAME_LENGTH_SECONDS = 20,
  parameter int unsigned COUNTDOWN_SECONDS   = 3,
  parameter int unsigned MOLE_UP_MS_START    = 2000,
  parameter int unsigned MOLE_UP_MS_MIN      = 500,
  parameter int unsigned MOLE_UP_STEP_MS     = 250,
  parameter int unsigned MOLE_DOWN_MS        = 1000,
  parameter int unsigned HITS_PER_LEVEL      = 5,
  parameter int unsigned NUM_LEVELS          = 8,
  parameter int unsigned MAX_SCORE           = 9999
) (
  input  logic                                                              clk,
  input  logic                                                              rst,
  input  logic                                                              start_pressed,
  input  logic                                                              pause_pressed,
  input  logic                                                              hit,
  input  logic                                                              miss,
  input  logic [$clog2(MAX_SCORE+1)-1:0]                                    score,
  output logic [2:0]                                                        state,
  output logic                                                              game_in_progress,
  output logic [((COUNTDOWN_SECONDS == 0) ? 1 : $clog2(COUNTDOWN_SECONDS+1))-1:0] countdown_value,
  output logic [$clog2(GAME_LENGTH_SECONDS+1)-1:0]                          seconds_left,
  output logic [$clog2(GAME_LENGTH_SECONDS*1000+1)-1:0]                     ms_left,
  output logic                                                              mole_up,
  output logic                                                              mole_tick,
  output logic [((NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1)-1:0]            level,
  output logic                                                              game_over_pulse,
  output logic [$clog2(MAX_SCORE+1)-1:0]                                    high_score,
  output logic                                                              new_high_score
);

  localparam int unsigned SCORE_W = $clog2(MAX_SCORE+1);
  localparam int unsigned CD_W    = (COUNTDOWN_SECONDS == 0) ? 1 : $clog2(COUNTDOWN_SECONDS+1);
  localparam int unsigned SEC_W   = $clog2(GAME_LENGTH_SECONDS+1);
  localparam int unsigned MS_W    = $clog2(GAME_LENGTH_SECONDS*1000+1);
  localparam int unsigned LVL_W   = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int unsigned PRE_W   = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam int unsigned STK_W   = $clog2(HITS_PER_LEVEL+1);
  localparam int unsigned PH_MAX0 = (MOLE_UP_MS_START > MOLE_DOWN_MS) ? MOLE_UP_MS_START : MOLE_DOWN_MS;
  localparam int unsigned PH_MAX  = (PH_MAX0 > MOLE_UP_MS_MIN) ? PH_MAX0 : MOLE_UP_MS_MIN;
  localparam int unsigned PH_W    = $clog2(PH_MAX+1);
  localparam int unsigned MSEC_W  = 10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_PAUSED    = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  state_t               r_state,   w_state_nxt;
  logic [PRE_W-1:0]     r_presc,   w_presc_nxt;
  logic [MSEC_W-1:0]    r_msec,    w_msec_nxt;
  logic [CD_W-1:0]      r_cd,      w_cd_nxt;
  logic [SEC_W-1:0]     r_sec,     w_sec_nxt;
  logic [MS_W-1:0]      r_ms_left, w_ms_left_nxt;
  logic [PH_W-1:0]      r_phase,   w_phase_nxt;
  logic                 r_mole_up, w_mole_up_nxt;
  logic                 r_mole_tick, w_mole_tick_nxt;
  logic [LVL_W-1:0]     r_level,   w_level_nxt;
  logic [STK_W-1:0]     r_streak,  w_streak_nxt;
  logic                 r_gop,     w_gop_nxt;
  logic                 r_gip,     w_gip_nxt;
  logic [SCORE_W-1:0]   r_high,    w_high_nxt;
  logic                 r_nhs,     w_nhs_nxt;
  logic                 w_ms_tick;
  logic                 w_play_entry;

  // Mole up-time for a level, clamped at the floor without unsigned underflow
  function automatic logic [PH_W-1:0] up_time(input logic [LVL_W-1:0] lvl);
    int unsigned red;
    red = 32'(lvl) * MOLE_UP_STEP_MS;
    if (red + MOLE_UP_MS_MIN >= MOLE_UP_MS_START) up_time = PH_W'(MOLE_UP_MS_MIN);
    else                                          up_time = PH_W'(MOLE_UP_MS_START - red);
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_msec      <= '0;
      r_cd        <= '0;
      r_sec       <= '0;
      r_ms_left   <= '0;
      r_phase     <= '0;
      r_mole_up   <= 1'b0;
      r_mole_tick <= 1'b0;
      r_level     <= '0;
      r_streak    <= '0;
      r_gop       <= 1'b0;
      r_gip       <= 1'b0;
      r_high      <= '0;
      r_nhs       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_presc     <= w_presc_nxt;
      r_msec      <= w_msec_nxt;
      r_cd        <= w_cd_nxt;
      r_sec       <= w_sec_nxt;
      r_ms_left   <= w_ms_left_nxt;
      r_phase     <= w_phase_nxt;
      r_mole_up   <= w_mole_up_nxt;
      r_mole_tick <= w_mole_tick_nxt;
      r_level     <= w_level_nxt;
      r_streak    <= w_streak_nxt;
      r_gop       <= w_gop_nxt;
      r_gip       <= w_gip_nxt;
      r_high      <= w_high_nxt;
      r_nhs       <= w_nhs_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_presc_nxt     = r_presc;
    w_msec_nxt      = r_msec;
    w_cd_nxt        = r_cd;
    w_sec_nxt       = r_sec;
    w_ms_left_nxt   = r_ms_left;
    w_phase_nxt     = r_phase;
    w_mole_up_nxt   = r_mole_up;
    w_mole_tick_nxt = 1'b0;
    w_level_nxt     = r_level;
    w_streak_nxt    = r_streak;
    w_gop_nxt       = 1'b0;
    w_high_nxt      = r_high;
    w_nhs_nxt       = r_nhs;
    w_play_entry    = 1'b0;
    w_ms_tick       = ((r_state == S_COUNTDOWN) || (r_state == S_PLAY)) &&
                      (r_presc == PRE_W'(CLKS_PER_MS - 1));

    case (r_state)
      S_IDLE, S_GAME_OVER: begin
        w_presc_nxt = '0;
        w_msec_nxt  = '0;
        if (start_pressed) begin
          w_nhs_nxt = 1'b0;
          if (COUNTDOWN_SECONDS == 0) begin
            w_play_entry = 1'b1;
          end else begin
            w_cd_nxt    = CD_W'(COUNTDOWN_SECONDS);
            w_state_nxt = S_COUNTDOWN;
          end
        end
      end
      S_COUNTDOWN: begin
        w_presc_nxt = w_ms_tick ? '0 : r_presc + PRE_W'(1);
        if (w_ms_tick) begin
          if (r_msec == MSEC_W'(999)) begin
            w_msec_nxt = '0;
            w_cd_nxt   = r_cd - CD_W'(1);
            if (r_cd == CD_W'(1)) w_play_entry = 1'b1;
          end else begin
            w_msec_nxt = r_msec + MSEC_W'(1);
          end
        end
      end
      S_PLAY: begin
        w_presc_nxt = w_ms_tick ? '0 : r_presc + PRE_W'(1);
        // Hit streak and level; miss wins over a simultaneous hit
        if (miss) begin
          w_streak_nxt = '0;
        end else if (hit) begin
          if (r_streak == STK_W'(HITS_PER_LEVEL - 1)) begin
            w_streak_nxt = '0;
            if (r_level != LVL_W'(NUM_LEVELS - 1)) w_level_nxt = r_level + LVL_W'(1);
          end else begin
            w_streak_nxt = r_streak + STK_W'(1);
          end
        end
        if (w_ms_tick && (r_ms_left == MS_W'(1))) begin
          // Game end overrides any mole phase expiry and pause in this cycle
          w_state_nxt   = S_GAME_OVER;
          w_gop_nxt     = 1'b1;
          w_ms_left_nxt = '0;
          w_sec_nxt     = '0;
          w_msec_nxt    = '0;
          w_mole_up_nxt = 1'b0;
          if (score > r_high) begin
            w_high_nxt = score;
            w_nhs_nxt  = 1'b1;
          end
        end else begin
          if (w_ms_tick) begin
            w_ms_left_nxt = r_ms_left - MS_W'(1);
            if (r_msec == MSEC_W'(999)) begin
              w_msec_nxt = '0;
              w_sec_nxt  = r_sec - SEC_W'(1);
            end else begin
              w_msec_nxt = r_msec + MSEC_W'(1);
            end
            // Up-load samples the current level, so level changes apply at the next up phase
            if (r_phase == PH_W'(1)) begin
              w_mole_up_nxt = ~r_mole_up;
              if (r_mole_up) begin
                w_phase_nxt = PH_W'(MOLE_DOWN_MS);
              end else begin
                w_phase_nxt     = up_time(r_level);
                w_mole_tick_nxt = 1'b1;
              end
            end else begin
              w_phase_nxt = r_phase - PH_W'(1);
            end
          end
          if (pause_pressed) w_state_nxt = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (start_pressed || pause_pressed) w_state_nxt = S_PLAY;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_play_entry) begin
      w_state_nxt     = S_PLAY;
      w_presc_nxt     = '0;
      w_msec_nxt      = '0;
      w_ms_left_nxt   = MS_W'(GAME_LENGTH_SECONDS * 1000);
      w_sec_nxt       = SEC_W'(GAME_LENGTH_SECONDS);
      w_level_nxt     = '0;
      w_streak_nxt    = '0;
      w_mole_up_nxt   = 1'b1;
      w_mole_tick_nxt = 1'b1;
      w_phase_nxt     = up_time(LVL_W'(0));
    end

    w_gip_nxt = (w_state_nxt == S_PLAY);
  end

  assign state            = r_state;
  assign game_in_progress = r_gip;
  assign countdown_value  = r_cd;
  assign seconds_left     = r_sec;
  assign ms_left          = r_ms_left;
  assign mole_up          = r_mole_up;
  assign mole_tick        = r_mole_tick;
  assign level            = r_level;
  assign game_over_pulse  = r_gop;
  assign high_score       = r_high;
  assign new_high_score   = r_nhs;

endmodule

// File: tb/tb_whack_a_mole_game_controller.sv
`timescale 1ns/1ps
module tb_whack_a_mole_game_controller;

  localparam int CLKS   = 2;
  localparam int GLS    = 2;
  localparam int CDS    = 1;
  localparam int UP0    = 40;
  localparam int UPMIN  = 20;
  localparam int UPSTEP = 10;
  localparam int DOWN   = 10;
  localparam int HPL    = 2;
  localparam int NLV    = 4;
  localparam int MAXS   = 9999;

  localparam int SCW  = $clog2(MAXS+1);
  localparam int CDW  = (CDS == 0) ? 1 : $clog2(CDS+1);
  localparam int SECW = $clog2(GLS+1);
  localparam int MSW  = $clog2(GLS*1000+1);
  localparam int LVW  = (NLV > 1) ? $clog2(NLV) : 1;
  localparam int WALL = 3 + 1 + CDW + SECW + MSW + 1 + 1 + LVW + 1 + SCW + 1;

  localparam int M_IDLE = 0, M_CD = 1, M_PLAY = 2, M_PAUSED = 3, M_GO = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start_pressed = 1'b0, pause_pressed = 1'b0, hit = 1'b0, miss = 1'b0;
  logic [SCW-1:0]  score = '0;
  logic [2:0]      state;
  logic            game_in_progress;
  logic [CDW-1:0]  countdown_value;
  logic [SECW-1:0] seconds_left;
  logic [MSW-1:0]  ms_left;
  logic            mole_up, mole_tick;
  logic [LVW-1:0]  level;
  logic            game_over_pulse;
  logic [SCW-1:0]  high_score;
  logic            new_high_score;

  whack_a_mole_game_controller #(
    .CLKS_PER_MS(CLKS), .GAME_LENGTH_SECONDS(GLS), .COUNTDOWN_SECONDS(CDS),
    .MOLE_UP_MS_START(UP0), .MOLE_UP_MS_MIN(UPMIN), .MOLE_UP_STEP_MS(UPSTEP),
    .MOLE_DOWN_MS(DOWN), .HITS_PER_LEVEL(HPL), .NUM_LEVELS(NLV), .MAX_SCORE(MAXS)
  ) dut (
    .clk(clk), .rst(rst), .start_pressed(start_pressed), .pause_pressed(pause_pressed),
    .hit(hit), .miss(miss), .score(score), .state(state),
    .game_in_progress(game_in_progress), .countdown_value(countdown_value),
    .seconds_left(seconds_left), .ms_left(ms_left), .mole_up(mole_up),
    .mole_tick(mole_tick), .level(level), .game_over_pulse(game_over_pulse),
    .high_score(high_score), .new_high_score(new_high_score)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: time kept in whole milliseconds, displays derived by rounding up
  int m_st, m_pre, m_cd_ms, m_ms, m_phase, m_up, m_tick, m_lvl, m_streak, m_hs, m_nhs, m_gop;

  function automatic int uptime(input int l);
    int t;
    t = UP0 - l * UPSTEP;
    return (t < UPMIN) ? UPMIN : t;
  endfunction

  task automatic enter_play();
    m_st = M_PLAY; m_pre = 0; m_ms = GLS * 1000; m_lvl = 0; m_streak = 0;
    m_up = 1; m_tick = 1; m_phase = uptime(0);
  endtask

  task automatic model_step(input bit r, input bit s, input bit p, input bit h,
                            input bit m, input int sc);
    int  st0, lvl0;
    bit  tick;
    m_tick = 0; m_gop = 0;
    if (r) begin
      m_st = M_IDLE; m_pre = 0; m_cd_ms = 0; m_ms = 0; m_phase = 0; m_up = 0;
      m_lvl = 0; m_streak = 0; m_hs = 0; m_nhs = 0;
      return;
    end
    st0  = m_st;
    lvl0 = m_lvl;
    tick = ((st0 == M_CD) || (st0 == M_PLAY)) && (m_pre == CLKS - 1);
    if (st0 == M_CD || st0 == M_PLAY) m_pre = tick ? 0 : m_pre + 1;
    else if (st0 != M_PAUSED)         m_pre = 0;
    case (st0)
      M_IDLE, M_GO: if (s) begin
        m_nhs = 0;
        if (CDS == 0) enter_play();
        else begin m_st = M_CD; m_cd_ms = CDS * 1000; end
      end
      M_CD: if (tick) begin
        m_cd_ms--;
        if (m_cd_ms == 0) enter_play();
      end
      M_PLAY: begin
        if (m) m_streak = 0;
        else if (h) begin
          m_streak++;
          if (m_streak == HPL) begin
            m_streak = 0;
            if (m_lvl < NLV - 1) m_lvl++;
          end
        end
        if (tick && m_ms == 1) begin
          m_ms = 0; m_up = 0; m_st = M_GO; m_gop = 1;
          if (sc > m_hs) begin m_hs = sc; m_nhs = 1; end
        end else begin
          if (tick) begin
            m_ms--;
            m_phase--;
            if (m_phase == 0) begin
              if (m_up != 0) begin m_up = 0; m_phase = DOWN; end
              else begin m_up = 1; m_phase = uptime(lvl0); m_tick = 1; end
            end
          end
          if (p) m_st = M_PAUSED;
        end
      end
      M_PAUSED: if (s || p) m_st = M_PLAY;
      default: ;
    endcase
  endtask

  task automatic cmp_model();
    logic [WALL-1:0] g, e;
    g = {state, game_in_progress, countdown_value, seconds_left, ms_left, mole_up,
         mole_tick, level, game_over_pulse, high_score, new_high_score};
    e = {3'(m_st), 1'(m_st == M_PLAY), CDW'((m_cd_ms + 999) / 1000),
         SECW'((m_ms + 999) / 1000), MSW'(m_ms), 1'(m_up), 1'(m_tick), LVW'(m_lvl),
         1'(m_gop), SCW'(m_hs), 1'(m_nhs)};
    n_vec++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL model cyc=%0d got st=%0d ms=%0d up=%0d lvl=%0d hs=%0d vec=%h exp st=%0d ms=%0d up=%0d lvl=%0d hs=%0d vec=%h",
               cyc, state, ms_left, mole_up, level, high_score, g,
               m_st, m_ms, m_up, m_lvl, m_hs, e);
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, sample 1 ns later
  task automatic cycle(input bit r, input bit s, input bit p, input bit h, input bit m);
    rst = r; start_pressed = s; pause_pressed = p; hit = h; miss = m;
    @(posedge clk);
    model_step(r, s, p, h, m, int'(score));
    #1;
    cmp_model();
    rst = 0; start_pressed = 0; pause_pressed = 0; hit = 0; miss = 0;
    cyc++;
  endtask

  task automatic start_and_wait_play(output int n);
    cycle(0, 1, 0, 0, 0);
    n = 0;
    while (state != 3'd2 && n < 2100) begin
      cycle(0, 0, 0, 0, 0);
      n++;
    end
  endtask

  typedef struct {
    bit r; bit s; bit p; bit h; bit m;
    int e_st; int e_cd; int e_gip;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int n, idx, fall, rise, go, sec999, since, up_start, nph, prev_up;
    int dur[4];
    bit h;

    tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0};  // reset
    tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 0};  // idle holds
    tbl[2] = '{0, 0, 1, 0, 0, 0, 0, 0};  // pause ignored in IDLE
    tbl[3] = '{0, 1, 1, 0, 0, 1, 1, 0};  // start wins over pause
    tbl[4] = '{0, 0, 1, 0, 0, 1, 1, 0};  // pause ignored in COUNTDOWN
    tbl[5] = '{0, 1, 0, 0, 0, 1, 1, 0};  // start ignored in COUNTDOWN
    tbl[6] = '{0, 0, 0, 1, 1, 1, 1, 0};  // hit/miss ignored in COUNTDOWN
    tbl[7] = '{1, 0, 0, 0, 0, 0, 0, 0};  // reset from COUNTDOWN
    tbl[8] = '{0, 1, 0, 0, 0, 1, 1, 0};
    tbl[9] = '{1, 1, 0, 0, 0, 0, 0, 0};  // reset beats start

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].h, tbl[i].m);
      chk("tbl_state", int'(state), tbl[i].e_st);
      chk("tbl_countdown", int'(countdown_value), tbl[i].e_cd);
      chk("tbl_gip", int'(game_in_progress), tbl[i].e_gip);
    end
    chk("rst_high_score", int'(high_score), 0);
    chk("rst_ms_left", int'(ms_left), 0);

    // Game A: countdown latency and a full game with no hits
    score = SCW'(37);
    start_and_wait_play(n);
    chk("cd_to_play_clks", n, 2000);
    chk("entry_mole_tick", int'(mole_tick), 1);
    chk("entry_ms_left", int'(ms_left), 2000);
    chk("entry_seconds_left", int'(seconds_left), 2);
    chk("entry_gip", int'(game_in_progress), 1);
    idx = 0; fall = -1; rise = -1; go = -1; sec999 = -1;
    while (go < 0 && idx < 4100) begin
      cycle(0, 0, 0, 0, 0);
      idx++;
      if (fall < 0 && !mole_up) fall = idx;
      else if (fall >= 0 && rise < 0 && mole_up) rise = idx;
      if (ms_left == MSW'(999)) sec999 = int'(seconds_left);
      if (game_over_pulse) go = idx;
    end
    chk("first_up_clks", fall, 80);
    chk("first_down_clks", rise - fall, 20);
    chk("sec_at_ms999", sec999, 1);
    chk("game_over_clks", go, 4000);
    chk("go_state", int'(state), 4);
    chk("go_mole_up", int'(mole_up), 0);
    chk("go_seconds_left", int'(seconds_left), 0);
    chk("game1_high", int'(high_score), 37);
    chk("game1_new_high", int'(new_high_score), 1);

    // Game B: levels, hit+miss priority, start ignored in PLAY
    score = SCW'(20);
    start_and_wait_play(n);
    chk("gameB_enter", int'(state), 2);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 0);
    chk("hit_miss_level", int'(level), 0);
    cycle(0, 1, 0, 0, 0);
    chk("start_in_play", int'(state), 2);
    cycle(0, 0, 0, 0, 1);
    idx = 5; since = 5; up_start = 0; nph = 0; prev_up = 1;
    while (nph < 4 && idx < 2000) begin
      h = (since == 10) || (since == 12);
      cycle(0, 0, 0, h, 0);
      idx++; since++;
      if (mole_tick) begin since = 0; up_start = idx; end
      if (prev_up != 0 && !mole_up) begin dur[nph] = idx - up_start; nph++; end
      prev_up = int'(mole_up);
    end
    chk("up_phase0_clks", dur[0], 80);
    chk("up_phase1_clks", dur[1], 60);
    chk("up_phase2_clks", dur[2], 40);
    chk("up_phase3_clks", dur[3], 40);
    chk("level_saturated", int'(level), 3);
    n = 0;
    while (state != 3'd4 && n < 4100) begin cycle(0, 0, 0, 0, 0); n++; end
    chk("game2_state", int'(state), 4);
    chk("game2_high", int'(high_score), 37);
    chk("game2_new_high", int'(new_high_score), 0);

    // Game C: pause at 1500 ms for 10000 clks, resume with start+pause together
    score = SCW'(50);
    start_and_wait_play(n);
    n = 0;
    while (ms_left != MSW'(1500) && n < 4000) begin cycle(0, 0, 0, 0, 0); n++; end
    cycle(0, 0, 1, 0, 0);
    chk("pause_state", int'(state), 3);
    chk("pause_gip", int'(game_in_progress), 0);
    repeat (10000) cycle(0, 0, 0, 0, 0);
    chk("paused_ms_left", int'(ms_left), 1500);
    chk("paused_mole_up", int'(mole_up), 1);
    chk("paused_state", int'(state), 3);
    cycle(0, 1, 1, 0, 0);
    chk("resume_state", int'(state), 2);
    n = 0;
    while (!game_over_pulse && n < 3100) begin cycle(0, 0, 0, 0, 0); n++; end
    chk("resume_to_go_clks", n, 2999);
    chk("game3_high", int'(high_score), 50);
    chk("game3_new_high", int'(new_high_score), 1);

    // Reset mid-PLAY and mid-PAUSED
    start_and_wait_play(n);
    repeat (100) cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("rst_play_state", int'(state), 0);
    chk("rst_play_high", int'(high_score), 0);
    chk("rst_play_ms", int'(ms_left), 0);
    chk("rst_play_mole", int'(mole_up), 0);
    start_and_wait_play(n);
    repeat (300) cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 1, 0, 0);
    repeat (5) cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("rst_pause_state", int'(state), 0);
    chk("rst_pause_level", int'(level), 0);
    chk("rst_pause_gip", int'(game_in_progress), 0);

    // Randomised traffic against the model
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 99) == 0) score = SCW'($urandom_range(0, MAXS));
      cycle($urandom_range(0, 9999) == 0, $urandom_range(0, 199) == 0,
            $urandom_range(0, 599) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/whack_a_mole_game_controller.md
Name: whack_a_mole_game_controller

Overview:
- Parametrised successor of the game-control path: one block owns the game state machine, millisecond timebase, game countdown timer and mole up/down pacing.
- Adds a pre-game countdown, pause/resume, difficulty levels that shorten mole up-time, and a persistent high score.
- Sits between the debounced buttons and the mole generator, hit logic and displays.

Parameters:
- CLKS_PER_MS, 50000, clock cycles per millisecond tick.
- GAME_LENGTH_SECONDS, 20, play time per game.
- COUNTDOWN_SECONDS, 3, pre-game countdown; 0 means go straight to PLAY.
- MOLE_UP_MS_START, 2000, mole up-time at level 0.
- MOLE_UP_MS_MIN, 500, floor on mole up-time.
- MOLE_UP_STEP_MS, 250, up-time reduction per level.
- MOLE_DOWN_MS, 1000, mole down-time, fixed.
- HITS_PER_LEVEL, 5, consecutive hits needed to advance one level.
- NUM_LEVELS, 8, number of levels; level saturates at NUM_LEVELS-1.
- MAX_SCORE, 9999, score range.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start_pressed  in  1  one-cycle pulse from a debounced button.
- pause_pressed  in  1  one-cycle pulse from a debounced button.
- hit  in  1  one-cycle pulse, non-miss hit from hit logic.
- miss  in  1  one-cycle pulse from hit logic.
- score  in  $clog2(MAX_SCORE+1)  current score.
- state  out  3  encoding: 0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 PAUSED, 4 GAME_OVER.
- game_in_progress  out  1  high only in PLAY.
- countdown_value  out  $clog2(COUNTDOWN_SECONDS+1)  countdown seconds remaining.
- seconds_left  out  $clog2(GAME_LENGTH_SECONDS+1)  game time remaining, rounded up.
- ms_left  out  $clog2(GAME_LENGTH_SECONDS*1000+1)  game time remaining in ms.
- mole_up  out  1  mole phase level; 1 means moles are shown.
- mole_tick  out  1  one-cycle pulse on every 0->1 mole_up transition, requesting new positions.
- level  out  max(1,$clog2(NUM_LEVELS))  current difficulty.
- game_over_pulse  out  1  one-cycle pulse on the PLAY->GAME_OVER transition.
- high_score  out  $clog2(MAX_SCORE+1)  best score since rst.
- new_high_score  out  1  the last game set a new high score.

Behaviour:
- Reset: rst=1 forces state IDLE and clears every output and internal counter to 0, including high_score. rst has priority over every other input.
- Prescaler:
  - Counts 0..CLKS_PER_MS-1 in COUNTDOWN and PLAY; ms_tick is asserted on the terminal count.
  - Holds its value in PAUSED; cleared in IDLE and GAME_OVER.
- IDLE:
  - start_pressed loads countdown_value=COUNTDOWN_SECONDS, clears new_high_score and enters COUNTDOWN.
  - If COUNTDOWN_SECONDS=0, start_pressed performs the PLAY entry directly.
- COUNTDOWN:
  - An internal ms-in-second counter (0..999) advances on ms_tick. On wrap, countdown_value decrements.
  - The decrement from 1 to 0 performs PLAY entry in the same cycle.
  - pause_pressed and start_pressed are ignored.
- PLAY entry (a single cycle):
  - ms_left=GAME_LENGTH_SECONDS*1000, seconds_left=GAME_LENGTH_SECONDS.
  - level=0, hit streak=0.
  - mole_up=1, mole_tick=1, phase timer=up-time(0).
- Up-time: up-time(L) = max(MOLE_UP_MS_START - L*MOLE_UP_STEP_MS, MOLE_UP_MS_MIN). Compute it without unsigned underflow.
- PLAY, on each ms_tick:
  - ms_left decrements.
  - The ms-in-second counter advances; on wrap, seconds_left decrements. seconds_left therefore equals ceil(ms_left/1000).
  - The phase timer decrements. On reaching 0, mole_up toggles and the timer reloads: MOLE_DOWN_MS when going down, up-time(level) when going up.
  - Level changes take effect only at the next up-load.
- Game end: when ms_left goes 1->0, the block enters GAME_OVER in the same cycle and game_over_pulse=1.
  - mole_up=0.
  - If score > high_score, then high_score<=score and new_high_score<=1.
  - A mole phase expiry in the same cycle is discarded, and no mole_tick is issued.
- Level logic (PLAY only):
  - On hit, the streak increments. When it reaches HITS_PER_LEVEL, level increments (saturating at NUM_LEVELS-1) and the streak clears.
  - miss clears the streak; level is unchanged.
  - hit and miss in the same cycle: miss wins.
  - hit and miss are ignored outside PLAY.
- Pause:
  - pause_pressed in PLAY enters PAUSED. All timers, prescaler, mole_up, level and streak freeze; game_in_progress=0.
  - In PAUSED, pause_pressed or start_pressed returns to PLAY, resuming with the exact frozen counts.
- Ignored inputs: start_pressed in PLAY is ignored; pause_pressed in IDLE and GAME_OVER is ignored.
- GAME_OVER:
  - Outputs hold; seconds_left=0, ms_left=0.
  - start_pressed behaves as in IDLE. It clears new_high_score; high_score is retained.
- Simultaneous start_pressed and pause_pressed: start has priority in IDLE and GAME_OVER, and both resume from PAUSED.
- mole_tick is never asserted outside PLAY entry or a 0->1 mole_up toggle.

Test Plan:
Bench parameters: CLKS_PER_MS=2, GAME_LENGTH_SECONDS=2, COUNTDOWN_SECONDS=1, MOLE_UP_MS_START=40, MOLE_UP_MS_MIN=20, MOLE_UP_STEP_MS=10, MOLE_DOWN_MS=10, HITS_PER_LEVEL=2, NUM_LEVELS=4.
- Reset, then start_pressed -> COUNTDOWN, countdown_value=1. PLAY is entered after 2000 clks with mole_tick=1, ms_left=2000, seconds_left=2, game_in_progress=1.
- Full game, no hits -> mole_up high for 80 clks then low for 20 clks, repeating. seconds_left reads 1 when ms_left=999. game_over_pulse arrives exactly 4000 clks after PLAY entry, then state=4 and mole_up=0.
- Hit pairs -> level advances 0,1,2,3 and stays at 3 after 8 hits. Up-phases measure 40,30,20,20 ms on successive up-loads. A hit+miss pulse in the same cycle leaves the streak at 0.
- pause_pressed at ms_left=1500 held for 10000 clks -> ms_left, mole_up and the phase timer are unchanged. After resume, game over occurs 1500 ms later.
- Game 1 with score=37 -> high_score=37, new_high_score=1. Game 2 with score=20 -> high_score=37, new_high_score=0. rst -> high_score=0.
- rst asserted mid-PLAY and mid-PAUSED -> next cycle state=0 and all outputs 0. start_pressed during PLAY -> no effect.
